c1_conv_engine: RTL and testbench
=================================

C1_CONV_ENGINE -- requirements
Module: c1_conv_engine

Interface
REQ-001 Parameter OUT_DIM, default 28, output feature-map width and height in windows.
REQ-002 Parameter ACC_W, default 22, accumulator and output width in bits, signed.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 i_start  in  1  single-cycle pulse; begins one OUT_DIM x OUT_DIM frame.
REQ-006 i_wgt_we / i_wgt_idx / i_wgt_data  in  1/5/8  weight write: enable, index 0..24 (row*5+col), signed value.
REQ-007 i_bias  in  16  signed bias, sampled on i_start.
REQ-008 i_win_valid  in  1  window present this cycle.
REQ-009 i_win_row_end  in  1  window is the last of its output row.
REQ-010 i_win_data  in  200  25 signed 8-bit taps; bits [8k+7:8k] = tap k = row*5+col.
REQ-011 o_win_ready  out  1  engine can take a window issued next cycle.
REQ-012 o_ofm_valid / o_ofm_data  out  1/ACC_W  result valid, signed result.
REQ-013 i_ofm_ready  in  1  downstream accepts result when high with o_ofm_valid.
REQ-014 o_ofm_row / o_ofm_col  out  5/5  coordinates of the current o_ofm_data.
REQ-015 o_done  out  1  one-cycle pulse after the last result is handed off.
REQ-016 o_proto_err  out  1  sticky window-protocol error flag.

Function
REQ-017 States: S_IDLE, S_RUN, S_DRAIN, S_DONE; encoding 0..3.
REQ-018 S_IDLE -> S_RUN on i_start; i_start outside S_IDLE is ignored.
REQ-019 S_RUN -> S_DRAIN on acceptance of window number OUT_DIM*OUT_DIM.
REQ-020 S_DRAIN -> S_DONE when skid buffer and pipeline are empty and the last result is handed off.
REQ-021 S_DONE: o_done=1 for one cycle, then S_IDLE.
REQ-022 Weight writes take effect only in S_IDLE and are ignored in other states.
REQ-023 Handshake: the producer registers windows, so a window may arrive one cycle after o_win_ready falls.
REQ-024 Every i_win_valid seen in S_RUN is accepted without loss.
REQ-025 A one-entry skid buffer holds an arriving window while the pipeline is stalled.
REQ-026 o_win_ready = (state==S_RUN) && skid empty && pipeline advancing.
REQ-027 Pipeline advances when !o_ofm_valid || i_ofm_ready; the skid buffer drains first, preserving order.
REQ-028 Stage 1 registers 25 signed 8x8 products, 16 bits each.
REQ-029 Stage 2 registers the sign-extended sum of the 25 products.
REQ-030 Stage 3 adds the sign-extended bias and drives o_ofm_data.
REQ-031 Latency is 3 cycles from window acceptance to o_ofm_valid with no stall.
REQ-032 Arithmetic is full-precision, with no wrap for any 8-bit inputs and ACC_W>=22.
REQ-033 o_ofm_col increments on each handoff, 0..OUT_DIM-1, then wraps to 0 and increments o_ofm_row.
REQ-034 o_proto_err is set if a window with i_win_row_end=1 arrives at input column != OUT_DIM-1.
REQ-035 o_proto_err is also set if column OUT_DIM-1 arrives with i_win_row_end=0, or if a window arrives in S_DRAIN or S_DONE; such windows are discarded.
REQ-036 Windows arriving in S_IDLE are ignored and do not set an error.
REQ-037 o_ofm_valid holds with o_ofm_data stable until handoff.

Reset
REQ-038 With reset_n=0 at a clock edge, the block enters S_IDLE.
REQ-039 Reset clears all outputs to 0, all counters to 0, skid and pipeline valid bits to 0, weights and bias to 0, and o_proto_err to 0.
REQ-040 Reset mid-frame discards in-flight results; no o_done is issued for that frame.

Configuration
REQ-041 Macro C1_CONV_RELU_EN defined: stage 3 outputs max(sum+bias, 0) and is still 3-cycle latency.
REQ-042 Macro C1_CONV_RELU_EN undefined: stage 3 outputs the raw signed sum+bias.

Verification
REQ-043 All weights 1, bias 0, all taps 1, ready always 1 -> 784 results of 25, first result 3 cycles after first accept, one o_done.
REQ-044 Weight k=12 is 1 and all others 0, taps = center pixel of a ramp image -> o_ofm_data(r,c) equals input(r+2,c+2).
REQ-045 All weights -128, taps -128, bias 32767 -> 442367 (RELU off).
REQ-046 All weights -1, taps 1, bias 0 -> -25 with RELU off and 0 with C1_CONV_RELU_EN.
REQ-047 i_ofm_ready toggled 1/0 randomly while the producer sends a window one cycle after ready drops -> no lost or duplicated results, order preserved, 784 handoffs.
REQ-048 i_win_row_end at column 5 -> o_proto_err=1 until reset; reset at result 100 -> S_IDLE, no o_done, and the next frame is correct.

Source files
------------

// File: rtl/c1_conv_engine.sv
`timescale 1ns/1ps
// c1_conv_engine: 5x5 convolution engine for one OUT_DIM x OUT_DIM output frame.
// Three-stage pipeline (products, sum, bias) behind a one-entry skid buffer, with
// a registered-producer window handshake and a stalling result handshake.
// Optional macro C1_CONV_RELU_EN clamps negative results to zero in stage 3.
module c1_conv_engine #(
  parameter int OUT_DIM = 28,
  parameter int ACC_W   = 22
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_start,
  input  logic                    i_wgt_we,
  input  logic [4:0]              i_wgt_idx,
  input  logic signed [7:0]       i_wgt_data,
  input  logic signed [15:0]      i_bias,
  input  logic                    i_win_valid,
  input  logic                    i_win_row_end,
  input  logic [199:0]            i_win_data,
  output logic                    o_win_ready,
  output logic                    o_ofm_valid,
  output logic signed [ACC_W-1:0] o_ofm_data,
  input  logic                    i_ofm_ready,
  output logic [4:0]              o_ofm_row,
  output logic [4:0]              o_ofm_col,
  output logic                    o_done,
  output logic                    o_proto_err
);

  localparam int FRAME = OUT_DIM * OUT_DIM;
  localparam int CW    = $clog2(FRAME + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state;
  logic signed [7:0]        wgt [25];
  logic signed [15:0]       bias;
  logic [CW-1:0]            win_cnt;
  logic [4:0]               in_col;
  logic                     skid_valid;
  logic [199:0]             skid_data;
  logic                     s1_valid;
  logic signed [15:0]       s1_prod [25];
  logic                     s2_valid;
  logic signed [ACC_W-1:0]  s2_sum;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  full_c;
  logic signed [ACC_W-1:0]  res_c;
  logic                     advance;
  logic                     win_acc;
  logic                     handoff;
  logic                     pipe_valid;
  logic [199:0]             pipe_data;
  logic                     col_last_in;
  logic                     last_out;

  assign advance     = !o_ofm_valid || i_ofm_ready;
  assign handoff     = o_ofm_valid && i_ofm_ready;
  assign win_acc     = (state == S_RUN) && i_win_valid;
  assign o_win_ready = (state == S_RUN) && !skid_valid && advance;
  assign pipe_valid  = skid_valid || win_acc;
  assign pipe_data   = skid_valid ? skid_data : i_win_data;
  assign col_last_in = (in_col == 5'(OUT_DIM - 1));
  assign last_out    = (o_ofm_row == 5'(OUT_DIM - 1)) && (o_ofm_col == 5'(OUT_DIM - 1));

  // Adder tree over the registered products, sign-extended to the accumulator width
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < 25; k++) begin
      sum_c = sum_c + ACC_W'(s1_prod[k]);
    end
  end

  // Bias add and optional clamp for the final stage
  always_comb begin
    full_c = s2_sum + ACC_W'(bias);
`ifdef C1_CONV_RELU_EN
    res_c = full_c[ACC_W-1] ? '0 : full_c;
`else
    res_c = full_c;
`endif
  end

  // Weight and bias registers, writable only while idle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 25; k++) wgt[k] <= '0;
      bias <= '0;
    end else if (state == S_IDLE) begin
      if (i_wgt_we && (i_wgt_idx < 5'd25)) wgt[i_wgt_idx] <= i_wgt_data;
      if (i_start) bias <= i_bias;
    end
  end

  // Skid buffer and the three pipeline stages; everything moves together on advance
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      s1_valid    <= 1'b0;
      for (int k = 0; k < 25; k++) s1_prod[k] <= '0;
      s2_valid    <= 1'b0;
      s2_sum      <= '0;
      o_ofm_valid <= 1'b0;
      o_ofm_data  <= '0;
    end else if (advance) begin
      s1_valid <= pipe_valid;
      for (int k = 0; k < 25; k++) begin
        s1_prod[k] <= 16'($signed(pipe_data[8*k +: 8])) * 16'(wgt[k]);
      end
      s2_valid    <= s1_valid;
      s2_sum      <= sum_c;
      o_ofm_valid <= s2_valid;
      o_ofm_data  <= res_c;
      skid_valid  <= skid_valid && win_acc;
      if (skid_valid && win_acc) skid_data <= i_win_data;
    end else if (win_acc && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= i_win_data;
    end
  end

  // Frame control FSM with window/result counters, done pulse and protocol checks
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      win_cnt     <= '0;
      in_col      <= '0;
      o_ofm_row   <= '0;
      o_ofm_col   <= '0;
      o_done      <= 1'b0;
      o_proto_err <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (handoff) begin
        if (o_ofm_col == 5'(OUT_DIM - 1)) begin
          o_ofm_col <= '0;
          o_ofm_row <= o_ofm_row + 5'd1;
        end else begin
          o_ofm_col <= o_ofm_col + 5'd1;
        end
      end
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state     <= S_RUN;
            win_cnt   <= '0;
            in_col    <= '0;
            o_ofm_row <= '0;
            o_ofm_col <= '0;
          end
        end
        S_RUN: begin
          if (win_acc) begin
            if (i_win_row_end != col_last_in) o_proto_err <= 1'b1;
            in_col  <= col_last_in ? 5'd0 : in_col + 5'd1;
            win_cnt <= win_cnt + CW'(1);
            if (win_cnt == CW'(FRAME - 1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (i_win_valid) o_proto_err <= 1'b1;
          if (handoff && last_out && !skid_valid && !s1_valid && !s2_valid) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end
        end
        S_DONE: begin
          if (i_win_valid) o_proto_err <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c1_conv_engine.sv
`timescale 1ns/1ps
// tb_c1_conv_engine: scoreboard bench for c1_conv_engine. The producer pushes the
// hand-derived expected result for every window it issues; an independent monitor
// pops and compares on every result handoff. Honours C1_CONV_RELU_EN if defined.
module tb_c1_conv_engine;

  localparam int OUT_DIM = 28;
  localparam int ACC_W   = 22;
  localparam int FRAME   = OUT_DIM * OUT_DIM;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_start;
  logic              i_wgt_we;
  logic [4:0]        i_wgt_idx;
  logic [7:0]        i_wgt_data;
  logic [15:0]       i_bias;
  logic              i_win_valid;
  logic              i_win_row_end;
  logic [199:0]      i_win_data;
  logic              o_win_ready;
  logic              o_ofm_valid;
  logic [ACC_W-1:0]  o_ofm_data;
  logic              i_ofm_ready;
  logic [4:0]        o_ofm_row;
  logic [4:0]        o_ofm_col;
  logic              o_done;
  logic              o_proto_err;

  typedef struct {
    int data;
    int row;
    int col;
  } exp_t;

  exp_t expq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   handoffs   = 0;
  int   done_cnt   = 0;
  int   cyc        = 0;
  int   first_acc  = -1;
  int   first_out  = -1;
  bit   measure    = 1'b0;
  bit   rand_ready = 1'b0;

  c1_conv_engine #(.OUT_DIM(OUT_DIM), .ACC_W(ACC_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_start       (i_start),
    .i_wgt_we      (i_wgt_we),
    .i_wgt_idx     (i_wgt_idx),
    .i_wgt_data    (i_wgt_data),
    .i_bias        (i_bias),
    .i_win_valid   (i_win_valid),
    .i_win_row_end (i_win_row_end),
    .i_win_data    (i_win_data),
    .o_win_ready   (o_win_ready),
    .o_ofm_valid   (o_ofm_valid),
    .o_ofm_data    (o_ofm_data),
    .i_ofm_ready   (i_ofm_ready),
    .o_ofm_row     (o_ofm_row),
    .o_ofm_col     (o_ofm_col),
    .o_done        (o_done),
    .o_proto_err   (o_proto_err)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: either always high or a random 1/0 per cycle
  always @(posedge clk) begin
    #1;
    i_ofm_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic checkOutput(input string name, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int img(input int y, input int x);
    return y * 4 + x - 100;
  endfunction

  function automatic int relu(input int v);
`ifdef C1_CONV_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Mode 0: taps 1; mode 1: ramp image; mode 2: taps -128; mode 3: taps 1
  function automatic logic [199:0] mkWin(input int mode, input int r, input int c);
    logic [199:0] w;
    int t;
    w = '0;
    for (int k = 0; k < 25; k++) begin
      case (mode)
        1:       t = img(r + k / 5, c + k % 5);
        2:       t = -128;
        default: t = 1;
      endcase
      w[8*k +: 8] = 8'(t);
    end
    return w;
  endfunction

  // Hand-derived expected results per mode
  function automatic int expVal(input int mode, input int r, input int c);
    case (mode)
      0:       return 25;
      1:       return relu(img(r + 2, c + 2));
      2:       return relu(442367);
      default: return relu(-25);
    endcase
  endfunction

  // Scoreboard monitor: compare every handoff against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (o_done) done_cnt++;
      if (measure) begin
        if (i_win_valid && first_acc < 0) first_acc = cyc;
        if (o_ofm_valid && first_out < 0) first_out = cyc;
      end
      if (o_ofm_valid && i_ofm_ready) begin
        handoffs++;
        if (expq.size() == 0) begin
          checkOutput("unexpected result", 1, 0);
        end else begin
          e = expq.pop_front();
          checkOutput("ofm data", int'($signed(o_ofm_data)), e.data);
          checkOutput("ofm row", int'(o_ofm_row), e.row);
          checkOutput("ofm col", int'(o_ofm_col), e.col);
        end
      end
    end
  end

  task automatic loadWeights(input int mode);
    int w;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      case (mode)
        0:       w = 1;
        1:       w = (k == 12) ? 1 : 0;
        2:       w = -128;
        default: w = -1;
      endcase
      i_wgt_we   = 1'b1;
      i_wgt_idx  = 5'(k);
      i_wgt_data = 8'(w);
    end
    @(posedge clk); #1;
    i_wgt_we = 1'b0;
  endtask

  task automatic startFrame(input int b);
    handoffs  = 0;
    done_cnt  = 0;
    first_acc = -1;
    first_out = -1;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_bias  = 16'(b);
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Registered producer: a window is issued in the cycle after o_win_ready was seen high
  task automatic applyStimulus(input int mode, input bit bad, input int abort_at);
    int   idx;
    int   budget;
    int   r;
    int   c;
    logic rdy;
    exp_t e;
    idx    = 0;
    budget = 0;
    while (idx < FRAME) begin
      @(negedge clk);
      rdy = o_win_ready;
      if (abort_at > 0 && handoffs >= abort_at) break;
      budget++;
      if (budget > 30000) begin
        checkOutput("window issue timeout", idx, FRAME);
        break;
      end
      @(posedge clk); #1;
      if (rdy) begin
        r = idx / OUT_DIM;
        c = idx % OUT_DIM;
        i_win_valid   = 1'b1;
        i_win_data    = mkWin(mode, r, c);
        i_win_row_end = (c == OUT_DIM - 1) || (bad && r == 0 && c == 5);
        e.data = expVal(mode, r, c);
        e.row  = r;
        e.col  = c;
        expq.push_back(e);
        idx++;
      end else begin
        i_win_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    i_win_valid   = 1'b0;
    i_win_row_end = 1'b0;
  endtask

  task automatic finishFrame(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checkOutput({name, " done pulses"}, done_cnt, 1);
    checkOutput({name, " handoffs"}, handoffs, FRAME);
    checkOutput({name, " pending results"}, expq.size(), 0);
  endtask

  initial begin
    reset_n       = 1'b0;
    i_start       = 1'b0;
    i_wgt_we      = 1'b0;
    i_wgt_idx     = '0;
    i_wgt_data    = '0;
    i_bias        = '0;
    i_win_valid   = 1'b0;
    i_win_row_end = 1'b0;
    i_win_data    = '0;
    i_ofm_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("reset win_ready", int'(o_win_ready), 0);
    checkOutput("reset ofm_valid", int'(o_ofm_valid), 0);
    checkOutput("reset ofm_data", int'($signed(o_ofm_data)), 0);
    checkOutput("reset ofm_row", int'(o_ofm_row), 0);
    checkOutput("reset ofm_col", int'(o_ofm_col), 0);
    checkOutput("reset done", int'(o_done), 0);
    checkOutput("reset proto_err", int'(o_proto_err), 0);

    // A window offered while idle is ignored and raises no error
    @(posedge clk); #1;
    i_win_valid   = 1'b1;
    i_win_row_end = 1'b1;
    i_win_data    = mkWin(0, 0, 0);
    @(posedge clk); #1;
    i_win_valid   = 1'b0;
    i_win_row_end = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idle window proto_err", int'(o_proto_err), 0);
    checkOutput("idle window ofm_valid", int'(o_ofm_valid), 0);

    // All ones: every result 25, 3-cycle latency
    loadWeights(0);
    startFrame(0);
    measure = 1'b1;
    applyStimulus(0, 1'b0, 0);
    finishFrame("all ones");
    checkOutput("first result latency", first_out - first_acc, 3);
    measure = 1'b0;

    // Centre tap over a ramp with random backpressure; stray start and weight write ignored
    loadWeights(1);
    rand_ready = 1'b1;
    startFrame(0);
    fork
      applyStimulus(1, 1'b0, 0);
      begin
        repeat (300) @(posedge clk);
        #1;
        i_start    = 1'b1;
        i_wgt_we   = 1'b1;
        i_wgt_idx  = 5'd12;
        i_wgt_data = 8'd5;
        @(posedge clk); #1;
        i_start  = 1'b0;
        i_wgt_we = 1'b0;
      end
    join
    finishFrame("ramp random ready");
    rand_ready = 1'b0;

    // Extreme magnitudes with maximum bias
    loadWeights(2);
    startFrame(32767);
    applyStimulus(2, 1'b0, 0);
    finishFrame("extreme");

    // Negative result, clamped when the ReLU option is built in
    loadWeights(3);
    startFrame(0);
    applyStimulus(3, 1'b0, 0);
    finishFrame("negative");
    checkOutput("clean frames proto_err", int'(o_proto_err), 0);

    // Early row end raises a sticky error; reset mid-frame abandons the frame
    loadWeights(0);
    startFrame(0);
    applyStimulus(0, 1'b1, 100);
    @(negedge clk);
    checkOutput("proto_err sticky", int'(o_proto_err), 1);
    @(posedge clk); #1;
    reset_n     = 1'b0;
    i_win_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    expq.delete();
    done_cnt = 0;
    repeat (20) @(negedge clk);
    checkOutput("abandoned frame done", done_cnt, 0);
    checkOutput("post reset proto_err", int'(o_proto_err), 0);
    checkOutput("post reset ofm_valid", int'(o_ofm_valid), 0);
    checkOutput("post reset win_ready", int'(o_win_ready), 0);

    // The next frame after reset is correct
    loadWeights(1);
    startFrame(0);
    applyStimulus(1, 1'b0, 0);
    finishFrame("after reset");
    checkOutput("after reset proto_err", int'(o_proto_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
